// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer geometry and constants.
// Every file of the reorder buffer imports this package.
package reorder_buffer_pkg;
  localparam int ROB_SIZE   = 16;
  localparam int ROB_WIDTH  = 4;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;
  localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue: renames rd on issue, bypasses operands from entries or the CDB, flushes on mispredict.
// Issue, commit and flush outputs are combinational in their cycle; rdy_in low freezes all state and drops every enable.
module reorder_buffer #(
  parameter int ROB_SIZE = reorder_buffer_pkg::ROB_SIZE,
  parameter int ROB_W    = reorder_buffer_pkg::ROB_WIDTH,
  parameter int REG_W    = reorder_buffer_pkg::REG_WIDTH,
  parameter int DATA_W   = reorder_buffer_pkg::DATA_WIDTH
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              dec2rob_valid,
  input  logic [REG_W-1:0]  dec2rob_rd,
  input  logic [REG_W-1:0]  dec2rob_rs1,
  input  logic [REG_W-1:0]  dec2rob_rs2,
  output logic              rob2dec_full,
  output logic [ROB_W-1:0]  rob2dec_tag,
  output logic [REG_W-1:0]  rob2reg_rs1_request,
  output logic [REG_W-1:0]  rob2reg_rs2_request,
  input  logic [DATA_W-1:0] reg2rob_rs1_value,
  input  logic [DATA_W-1:0] reg2rob_rs2_value,
  input  logic              reg2rob_rs1_if_rename,
  input  logic              reg2rob_rs2_if_rename,
  input  logic [ROB_W-1:0]  reg2rob_rs1_rename,
  input  logic [ROB_W-1:0]  reg2rob_rs2_rename,
  output logic              rob2rs_rs1_ready,
  output logic              rob2rs_rs2_ready,
  output logic [DATA_W-1:0] rob2rs_rs1_value,
  output logic [DATA_W-1:0] rob2rs_rs2_value,
  output logic [ROB_W-1:0]  rob2rs_rs1_tag,
  output logic [ROB_W-1:0]  rob2rs_rs2_tag,
  output logic              rob2reg_reserve_enable,
  output logic [REG_W-1:0]  rob2reg_reserve_rd,
  output logic [ROB_W-1:0]  rob2reg_reserve_reorder,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              cdb_mispredict,
  input  logic [DATA_W-1:0] cdb_target,
  output logic              rob2reg_commit_enable,
  output logic [REG_W-1:0]  rob2reg_commit_des,
  output logic [DATA_W-1:0] rob2reg_commit_value,
  output logic [ROB_W-1:0]  rob2reg_commit_reorder,
  output logic              rob_flush,
  output logic [DATA_W-1:0] rob_flush_pc
);
  import reorder_buffer_pkg::*;

  localparam int CNT_W = ROB_W + 1;

  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  logic [ROB_SIZE-1:0] r_mispredict;
  logic [REG_W-1:0]    r_rd     [ROB_SIZE];
  logic [DATA_W-1:0]   r_value  [ROB_SIZE];
  logic [DATA_W-1:0]   r_target [ROB_SIZE];
  logic [ROB_W-1:0]    r_head;
  logic [ROB_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  logic                w_run;
  logic                w_full;
  logic                w_commit;
  logic                w_issue;
  logic [DATA_W:0]     w_rs1;
  logic [DATA_W:0]     w_rs2;

  // Bypass priority: architectural value, then a finished entry, then this cycle's CDB.
  function automatic logic [DATA_W:0] f_resolve(
    input logic              if_rename,
    input logic [ROB_W-1:0]  tag,
    input logic              ent_ready,
    input logic [DATA_W-1:0] ent_value,
    input logic [DATA_W-1:0] reg_value,
    input logic              bus_valid,
    input logic [ROB_W-1:0]  bus_tag,
    input logic [DATA_W-1:0] bus_value
  );
    if (!if_rename) return {TRUE, reg_value};
    if (ent_ready) return {TRUE, ent_value};
    if (bus_valid && (bus_tag == tag)) return {TRUE, bus_value};
    return {FALSE, {DATA_W{1'b0}}};
  endfunction

  assign w_run    = rdy_in && !rst_in;
  assign w_full   = (r_count == CNT_W'(ROB_SIZE));
  assign w_commit = w_run && r_busy[r_head] && r_ready[r_head];
  assign w_issue  = w_run && dec2rob_valid && !w_full && !rob_flush;

  assign rob2dec_full        = w_full;
  assign rob2dec_tag         = r_tail;
  assign rob2reg_rs1_request = dec2rob_rs1;
  assign rob2reg_rs2_request = dec2rob_rs2;

  assign w_rs1 = f_resolve(reg2rob_rs1_if_rename, reg2rob_rs1_rename, r_ready[reg2rob_rs1_rename],
                           r_value[reg2rob_rs1_rename], reg2rob_rs1_value, cdb_valid, cdb_tag, cdb_value);
  assign w_rs2 = f_resolve(reg2rob_rs2_if_rename, reg2rob_rs2_rename, r_ready[reg2rob_rs2_rename],
                           r_value[reg2rob_rs2_rename], reg2rob_rs2_value, cdb_valid, cdb_tag, cdb_value);

  assign rob2rs_rs1_ready = w_rs1[DATA_W];
  assign rob2rs_rs1_value = w_rs1[DATA_W-1:0];
  assign rob2rs_rs1_tag   = reg2rob_rs1_rename;
  assign rob2rs_rs2_ready = w_rs2[DATA_W];
  assign rob2rs_rs2_value = w_rs2[DATA_W-1:0];
  assign rob2rs_rs2_tag   = reg2rob_rs2_rename;

  assign rob2reg_reserve_enable  = w_issue && (dec2rob_rd != '0);
  assign rob2reg_reserve_rd      = dec2rob_rd;
  assign rob2reg_reserve_reorder = r_tail;

  assign rob2reg_commit_enable  = w_commit && (r_rd[r_head] != '0);
  assign rob2reg_commit_des     = r_rd[r_head];
  assign rob2reg_commit_value   = r_value[r_head];
  assign rob2reg_commit_reorder = r_head;
  assign rob_flush              = w_commit && r_mispredict[r_head];
  assign rob_flush_pc           = r_target[r_head];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy       <= '0;
      r_ready      <= '0;
      r_mispredict <= '0;
      r_head       <= ZERO_ROB;
      r_tail       <= ZERO_ROB;
      r_count      <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_rd[i]     <= '0;
        r_value[i]  <= '0;
        r_target[i] <= '0;
      end
    end else if (rdy_in) begin
      if (rob_flush) begin
        r_busy       <= '0;
        r_ready      <= '0;
        r_mispredict <= '0;
        r_head       <= ZERO_ROB;
        r_tail       <= ZERO_ROB;
        r_count      <= '0;
      end else begin
        // Results for entries not in flight are stale broadcasts and are dropped.
        if (cdb_valid && r_busy[cdb_tag]) begin
          r_ready[cdb_tag]      <= TRUE;
          r_value[cdb_tag]      <= cdb_value;
          r_mispredict[cdb_tag] <= cdb_mispredict;
          r_target[cdb_tag]     <= cdb_target;
        end
        if (w_commit) begin
          r_busy[r_head]       <= FALSE;
          r_ready[r_head]      <= FALSE;
          r_mispredict[r_head] <= FALSE;
          r_head               <= r_head + 1'b1;
        end
        if (w_issue) begin
          r_busy[r_tail]       <= TRUE;
          r_ready[r_tail]      <= FALSE;
          r_mispredict[r_tail] <= FALSE;
          r_rd[r_tail]         <= dec2rob_rd;
          r_tail               <= r_tail + 1'b1;
        end
        r_count <= r_count + CNT_W'(w_issue) - CNT_W'(w_commit);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: operand/issue vector table, directed corner sequences,
// then random traffic against a queue-based model of the retirement order.
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        dec2rob_valid;
  logic [4:0]  dec2rob_rd, dec2rob_rs1, dec2rob_rs2;
  logic        rob2dec_full;
  logic [3:0]  rob2dec_tag;
  logic [4:0]  rob2reg_rs1_request, rob2reg_rs2_request;
  logic [31:0] reg2rob_rs1_value, reg2rob_rs2_value;
  logic        reg2rob_rs1_if_rename, reg2rob_rs2_if_rename;
  logic [3:0]  reg2rob_rs1_rename, reg2rob_rs2_rename;
  logic        rob2rs_rs1_ready, rob2rs_rs2_ready;
  logic [31:0] rob2rs_rs1_value, rob2rs_rs2_value;
  logic [3:0]  rob2rs_rs1_tag, rob2rs_rs2_tag;
  logic        rob2reg_reserve_enable;
  logic [4:0]  rob2reg_reserve_rd;
  logic [3:0]  rob2reg_reserve_reorder;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic        rob2reg_commit_enable;
  logic [4:0]  rob2reg_commit_des;
  logic [31:0] rob2reg_commit_value;
  logic [3:0]  rob2reg_commit_reorder;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec2rob_valid(dec2rob_valid), .dec2rob_rd(dec2rob_rd),
    .dec2rob_rs1(dec2rob_rs1), .dec2rob_rs2(dec2rob_rs2),
    .rob2dec_full(rob2dec_full), .rob2dec_tag(rob2dec_tag),
    .rob2reg_rs1_request(rob2reg_rs1_request), .rob2reg_rs2_request(rob2reg_rs2_request),
    .reg2rob_rs1_value(reg2rob_rs1_value), .reg2rob_rs2_value(reg2rob_rs2_value),
    .reg2rob_rs1_if_rename(reg2rob_rs1_if_rename), .reg2rob_rs2_if_rename(reg2rob_rs2_if_rename),
    .reg2rob_rs1_rename(reg2rob_rs1_rename), .reg2rob_rs2_rename(reg2rob_rs2_rename),
    .rob2rs_rs1_ready(rob2rs_rs1_ready), .rob2rs_rs2_ready(rob2rs_rs2_ready),
    .rob2rs_rs1_value(rob2rs_rs1_value), .rob2rs_rs2_value(rob2rs_rs2_value),
    .rob2rs_rs1_tag(rob2rs_rs1_tag), .rob2rs_rs2_tag(rob2rs_rs2_tag),
    .rob2reg_reserve_enable(rob2reg_reserve_enable), .rob2reg_reserve_rd(rob2reg_reserve_rd),
    .rob2reg_reserve_reorder(rob2reg_reserve_reorder),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .rob2reg_commit_enable(rob2reg_commit_enable), .rob2reg_commit_des(rob2reg_commit_des),
    .rob2reg_commit_value(rob2reg_commit_value), .rob2reg_commit_reorder(rob2reg_commit_reorder),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clr();
    rdy_in = 1'b1; dec2rob_valid = 1'b0; dec2rob_rd = '0; dec2rob_rs1 = '0; dec2rob_rs2 = '0;
    reg2rob_rs1_value = '0; reg2rob_rs2_value = '0;
    reg2rob_rs1_if_rename = 1'b0; reg2rob_rs2_if_rename = 1'b0;
    reg2rob_rs1_rename = '0; reg2rob_rs2_rename = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mispredict = 1'b0; cdb_target = '0;
  endtask

  typedef struct {
    logic rdy; logic valid; logic [4:0] rd;
    logic ifr; logic [3:0] ren; logic [31:0] regv;
    logic cv; logic [3:0] ct; logic [31:0] cval;
    logic e_res; logic e_ready; logic [31:0] e_val;
  } vec_t;
  vec_t tbl[8];

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [3:0] tag; logic [4:0] rd; logic ready;
    logic [31:0] value; logic mis; logic [31:0] target;
  } ment_t;
  ment_t q[$];
  logic [3:0] m_tail;

  function automatic void model_op(input logic ifr, input logic [3:0] ren, input logic [31:0] rv,
                                   output logic ok, output logic [31:0] v);
    ok = 1'b0; v = '0;
    if (!ifr) begin ok = 1'b1; v = rv; return; end
    foreach (q[k]) if (q[k].tag == ren && q[k].ready) begin ok = 1'b1; v = q[k].value; return; end
    if (cdb_valid && cdb_tag == ren) begin ok = 1'b1; v = cdb_value; end
  endfunction

  function automatic logic [3:0] pick_tag();
    if (q.size() > 0 && $urandom_range(0, 2) != 0) return q[$urandom_range(0, q.size() - 1)].tag;
    return 4'($urandom);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m_full, m_commit, m_flush, m_issue, m_cen, ok1, ok2;
    logic [31:0] v1, v2;

    tbl[0] = '{1'b1, 1'b1, 5'd7,  1'b0, 4'd0,  32'hDEAD0001, 1'b0, 4'd0,  32'h0,        1'b1, 1'b1, 32'hDEAD0001};
    tbl[1] = '{1'b1, 1'b1, 5'd0,  1'b0, 4'd0,  32'h2,        1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 32'h2};
    tbl[2] = '{1'b0, 1'b1, 5'd9,  1'b0, 4'd0,  32'h3,        1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 32'h3};
    tbl[3] = '{1'b1, 1'b0, 5'd9,  1'b1, 4'd6,  32'h4,        1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 5'd31, 1'b1, 4'd6,  32'h4,        1'b1, 4'd6,  32'h55,       1'b1, 1'b1, 32'h55};
    tbl[5] = '{1'b1, 1'b0, 5'd0,  1'b1, 4'd6,  32'h4,        1'b1, 4'd7,  32'h66,       1'b0, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 5'd3,  1'b1, 4'd15, 32'h9,        1'b1, 4'd15, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[7] = '{1'b1, 1'b0, 5'd0,  1'b0, 4'd3,  32'h88,       1'b1, 4'd3,  32'h77,       1'b0, 1'b1, 32'h88};

    // Reset held with an issue request pending: nothing may be enabled.
    clr();
    rst_in = 1'b1; dec2rob_valid = 1'b1; dec2rob_rd = 5'd5;
    #2;
    chk("rst_full", rob2dec_full, 0);
    chk("rst_tag", rob2dec_tag, 0);
    chk("rst_reserve", rob2reg_reserve_enable, 0);
    chk("rst_commit", rob2reg_commit_enable, 0);
    chk("rst_flush", rob_flush, 0);
    tick(); tick();
    rst_in = 1'b0; dec2rob_valid = 1'b0;

    // Combinational issue/operand vectors on an empty buffer; requests drop before the edge.
    foreach (tbl[i]) begin
      rdy_in = tbl[i].rdy; dec2rob_valid = tbl[i].valid; dec2rob_rd = tbl[i].rd;
      reg2rob_rs1_if_rename = tbl[i].ifr; reg2rob_rs1_rename = tbl[i].ren; reg2rob_rs1_value = tbl[i].regv;
      reg2rob_rs2_if_rename = tbl[i].ifr; reg2rob_rs2_rename = tbl[i].ren; reg2rob_rs2_value = tbl[i].regv;
      cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_value = tbl[i].cval;
      #1;
      chk($sformatf("tbl%0d_reserve", i), rob2reg_reserve_enable, tbl[i].e_res);
      if (tbl[i].e_res) chk($sformatf("tbl%0d_res_rd", i), {rob2reg_reserve_rd, rob2reg_reserve_reorder}, {tbl[i].rd, 4'd0});
      chk($sformatf("tbl%0d_rs1_ready", i), rob2rs_rs1_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_rs2_ready", i), rob2rs_rs2_ready, tbl[i].e_ready);
      if (tbl[i].e_ready) chk($sformatf("tbl%0d_vals", i), {rob2rs_rs1_value, rob2rs_rs2_value}, {tbl[i].e_val, tbl[i].e_val});
      else chk($sformatf("tbl%0d_tags", i), {rob2rs_rs1_tag, rob2rs_rs2_tag}, {tbl[i].ren, tbl[i].ren});
      #1;
      clr();
      tick();
    end
    chk("tbl_no_state", rob2dec_tag, 0);

    // First issue, then fill to 16 entries (entry k>0 carries rd=k).
    dec2rob_valid = 1'b1; dec2rob_rd = 5'd5;
    #1;
    chk("iss0_reserve", {rob2reg_reserve_enable, rob2reg_reserve_rd, rob2reg_reserve_reorder}, {1'b1, 5'd5, 4'd0});
    tick();
    chk("iss0_tail", rob2dec_tag, 1);
    for (int i = 1; i < 16; i++) begin
      dec2rob_rd = 5'(i);
      #1;
      chk($sformatf("fill%0d_tag", i), rob2dec_tag, i);
      tick();
    end
    dec2rob_rd = 5'd9;
    #1;
    chk("full_flag", rob2dec_full, 1);
    chk("full_wrap_tag", rob2dec_tag, 0);
    chk("full_no_reserve", rob2reg_reserve_enable, 0);
    tick();
    dec2rob_valid = 1'b0;
    #1;
    chk("full_17th_ignored", {rob2dec_full, rob2dec_tag}, {1'b1, 4'd0});

    // Result for the head: committable only on the following cycle; full still blocks that cycle.
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h1234;
    #1;
    chk("cdb_head_not_same_cycle", rob2reg_commit_enable, 0);
    tick();
    cdb_valid = 1'b0; dec2rob_valid = 1'b1; dec2rob_rd = 5'd9;
    #1;
    chk("commit0", {rob2reg_commit_enable, rob2reg_commit_des, rob2reg_commit_value, rob2reg_commit_reorder},
        {1'b1, 5'd5, 32'h1234, 4'd0});
    chk("commit0_full_blocks_issue", rob2reg_reserve_enable, 0);
    tick();
    dec2rob_valid = 1'b0;
    #1;
    chk("after_commit0", {rob2dec_full, rob2dec_tag, rob2reg_commit_enable}, {1'b0, 4'd0, 1'b0});

    // Operand bypass: waiting on tag 3, then same-cycle CDB, then from the stored entry.
    reg2rob_rs1_if_rename = 1'b1; reg2rob_rs1_rename = 4'd3;
    reg2rob_rs2_if_rename = 1'b1; reg2rob_rs2_rename = 4'd4;
    #1;
    chk("rs1_wait", {rob2rs_rs1_ready, rob2rs_rs1_tag}, {1'b0, 4'd3});
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'hAA;
    #1;
    chk("rs1_cdb_bypass", {rob2rs_rs1_ready, rob2rs_rs1_value}, {1'b1, 32'hAA});
    chk("rs2_still_wait", {rob2rs_rs2_ready, rob2rs_rs2_tag}, {1'b0, 4'd4});
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("rs1_from_entry", {rob2rs_rs1_ready, rob2rs_rs1_value}, {1'b1, 32'hAA});
    clr();

    // Freeze: head 1 becomes ready, then rdy_in low blocks commit and ignores a CDB to entry 2.
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h11;
    tick();
    rdy_in = 1'b0; dec2rob_valid = 1'b1; dec2rob_rd = 5'd7;
    cdb_tag = 4'd2; cdb_mispredict = 1'b1; cdb_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("frozen%0d", i), {rob2reg_commit_enable, rob2reg_reserve_enable, rob_flush, rob2dec_tag},
          {1'b0, 1'b0, 1'b0, 4'd0});
      tick();
    end
    clr();
    #1;
    chk("release_commit", {rob2reg_commit_enable, rob2reg_commit_des, rob2reg_commit_value, rob2reg_commit_reorder},
        {1'b1, 5'd1, 32'h11, 4'd1});
    tick();
    #1;
    chk("frozen_cdb_ignored", {rob2reg_commit_enable, rob_flush}, {1'b0, 1'b0});

    // Mispredict at head 2: one-cycle flush, issue blocked, then empty.
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h0; cdb_mispredict = 1'b1; cdb_target = 32'h100;
    tick();
    clr();
    dec2rob_valid = 1'b1; dec2rob_rd = 5'd3;
    #1;
    chk("flush", {rob_flush, rob_flush_pc, rob2reg_reserve_enable}, {1'b1, 32'h100, 1'b0});
    chk("flush_commit", {rob2reg_commit_enable, rob2reg_commit_des}, {1'b1, 5'd2});
    tick();
    dec2rob_valid = 1'b0;
    #1;
    chk("after_flush", {rob_flush, rob2dec_full, rob2dec_tag, rob2reg_commit_enable}, {1'b0, 1'b0, 4'd0, 1'b0});

    // Reset in the middle of a commit abandons it.
    dec2rob_valid = 1'b1; dec2rob_rd = 5'd6;
    tick();
    dec2rob_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h5;
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("pre_reset_commit", rob2reg_commit_enable, 1);
    rst_in = 1'b1;
    #1;
    chk("reset_mid_commit", {rob2reg_commit_enable, rob2dec_full, rob2dec_tag}, {1'b0, 1'b0, 4'd0});
    tick();
    rst_in = 1'b0;
    #1;
    chk("after_reset_empty", {rob2reg_commit_enable, rob2dec_tag}, {1'b0, 4'd0});
    tick();

    // Random traffic against the queue model.
    q.delete(); m_tail = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy_in = ($urandom_range(0, 7) != 0);
      dec2rob_valid = ($urandom_range(0, 2) != 0);
      dec2rob_rd = 5'($urandom);
      dec2rob_rs1 = 5'($urandom); dec2rob_rs2 = 5'($urandom);
      reg2rob_rs1_value = $urandom; reg2rob_rs2_value = $urandom;
      reg2rob_rs1_if_rename = 1'($urandom); reg2rob_rs2_if_rename = 1'($urandom);
      reg2rob_rs1_rename = pick_tag(); reg2rob_rs2_rename = pick_tag();
      cdb_valid = 1'($urandom);
      cdb_tag = pick_tag();
      cdb_value = $urandom;
      cdb_mispredict = ($urandom_range(0, 19) == 0);
      cdb_target = $urandom;
      #1;
      m_full = (q.size() == 16);
      m_commit = rdy_in && (q.size() > 0) && q[0].ready;
      m_flush = m_commit && q[0].mis;
      m_cen = m_commit && (q[0].rd != 0);
      m_issue = dec2rob_valid && !m_full && rdy_in && !m_flush;
      chk("rnd_ctrl", {rob2dec_full, rob2dec_tag, rob2reg_reserve_enable, rob2reg_commit_enable, rob_flush},
          {m_full, m_tail, m_issue && (dec2rob_rd != 0), m_cen, m_flush});
      chk("rnd_request", {rob2reg_rs1_request, rob2reg_rs2_request}, {dec2rob_rs1, dec2rob_rs2});
      if (m_issue && dec2rob_rd != 0)
        chk("rnd_reserve", {rob2reg_reserve_rd, rob2reg_reserve_reorder}, {dec2rob_rd, m_tail});
      if (m_commit)
        chk("rnd_commit", {rob2reg_commit_des, rob2reg_commit_value, rob2reg_commit_reorder},
            {q[0].rd, q[0].value, q[0].tag});
      if (m_flush) chk("rnd_flush_pc", rob_flush_pc, q[0].target);
      model_op(reg2rob_rs1_if_rename, reg2rob_rs1_rename, reg2rob_rs1_value, ok1, v1);
      model_op(reg2rob_rs2_if_rename, reg2rob_rs2_rename, reg2rob_rs2_value, ok2, v2);
      chk("rnd_rs1", {rob2rs_rs1_ready, ok1 ? rob2rs_rs1_value : 32'(rob2rs_rs1_tag)},
          {ok1, ok1 ? v1 : 32'(reg2rob_rs1_rename)});
      chk("rnd_rs2", {rob2rs_rs2_ready, ok2 ? rob2rs_rs2_value : 32'(rob2rs_rs2_tag)},
          {ok2, ok2 ? v2 : 32'(reg2rob_rs2_rename)});
      tick();
      if (rdy_in) begin
        if (m_flush) begin
          q.delete(); m_tail = '0;
        end else begin
          if (cdb_valid)
            foreach (q[k]) if (q[k].tag == cdb_tag) begin
              q[k].ready = 1'b1; q[k].value = cdb_value;
              q[k].mis = cdb_mispredict; q[k].target = cdb_target;
            end
          if (m_commit) void'(q.pop_front());
          if (m_issue) begin
            q.push_back('{m_tail, dec2rob_rd, 1'b0, 32'h0, 1'b0, 32'h0});
            m_tail = m_tail + 4'd1;
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
